// File: rtl/elastic_pipe_reg_if.sv
// Valid/ready handshake bundle for elastic_pipe_reg: upstream (in_*) and downstream (out_*) sides.
// The slave modport is the register stage. The master modport is the surrounding datapath.
interface elastic_pipe_reg_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH flit slots with valid/ready on both sides, bubble collapsing,
// synchronous flush and a registered occupancy count.
module elastic_pipe_reg #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  elastic_pipe_reg_if.slave      bus,
  input  logic                   flush,
  output logic [CW-1:0]          count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] v_in;
  logic [WIDTH-1:0] d_in [DEPTH];
  logic             in_ready;
  logic             accept;
  logic             emit;

  // A slot may load when it is empty or its occupant is moving on this edge.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ~v_q[i] | rdy[i+1];
    end
  end

  assign in_ready = rdy[0] & ~flush;
  assign accept   = bus.in_valid & in_ready;
  assign emit     = v_q[DEPTH-1] & bus.out_ready;

  // What each slot would take if it loads: slot 0 from upstream, others from their predecessor.
  always_comb begin
    v_in    = '0;
    v_in[0] = accept;
    d_in[0] = bus.in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      v_in[i] = v_q[i-1];
      d_in[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      d_d[i] = d_q[i];
    end
    if (flush) begin
      v_d = '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (rdy[i]) begin
          v_d[i] = v_in[i];
          // Data only moves with a valid flit so bubbles leave the registers quiet.
          if (v_in[i]) begin
            d_d[i] = d_in[i];
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign count         = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomised and directed bench for elastic_pipe_reg: the driver pushes accepted flits into a
// scoreboard; the monitor checks handshake/count against a flit-position model and pops emitted data.
module tb_elastic_pipe_reg;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;

  elastic_pipe_reg_if #(.WIDTH(WIDTH)) bus ();

  elastic_pipe_reg #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .flush(flush),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb [$];
  int pos_q [$];
  bit last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Inputs change on the falling edge; an accepted flit is queued as expected output.
  task automatic drive(input bit rst, input bit iv, input bit ordy, input bit fl,
                       input logic [WIDTH-1:0] data);
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_data   = data;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    last_acc = rst && bus.in_valid && bus.in_ready;
    if (last_acc) sb.push_back(bus.in_data);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, ordy, 1'b0, '0);
  endtask

  // Monitor: flits sit in ordered slot positions; each advances one slot per edge unless the
  // flit ahead occupies the next slot after its own move. Head leaves from DEPTH-1 on out_ready.
  initial begin : monitor
    int exp_cnt;
    bit exp_ov, exp_ir;
    int limit;
    logic [WIDTH-1:0] exp_d;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'(!flush));
        pos_q.delete();
        sb.delete();
      end else begin
        exp_cnt = pos_q.size();
        exp_ov  = 1'b0;
        if (exp_cnt > 0) exp_ov = (pos_q[0] == int'(DEPTH) - 1);
        exp_ir  = !flush && (exp_cnt < int'(DEPTH) || bus.out_ready);
        chk("count", 32'(count), 32'(exp_cnt));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            chk("emit_without_flit", 32'(bus.out_valid), 0);
          end else begin
            exp_d = sb.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(exp_d));
          end
        end
        if (flush) begin
          pos_q.delete();
          sb.delete();
        end else begin
          if (exp_ov && bus.out_ready) void'(pos_q.pop_front());
          limit = int'(DEPTH);
          foreach (pos_q[k]) begin
            if (pos_q[k] + 1 < limit) pos_q[k] = pos_q[k] + 1;
            limit = pos_q[k];
          end
          if (exp_ir && bus.in_valid) pos_q.push_back(0);
        end
      end
    end
  end

  initial begin : driver
    int nxt;
    int guard;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // First flit straight after reset release.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
    idle(6, 1'b1);

    // Back-to-back streaming.
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'(i));
    idle(6, 1'b1);

    // Back-pressure fill, then release.
    nxt = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h50 + nxt));
      if (last_acc) nxt++;
    end
    chk("bp_accepted", 32'(nxt), DEPTH);
    guard = 0;
    while (nxt < 6 && guard < 20) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h50 + nxt));
      if (last_acc) nxt++;
      guard++;
    end
    chk("bp_all_accepted", 32'(nxt), 6);
    idle(8, 1'b1);

    // Bubble collapse under stall.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h11);
    idle(1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h22);
    idle(4, 1'b0);
    idle(6, 1'b1);

    // Flush with an output transfer in the same cycle.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i));
    idle(1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h99);
    idle(4, 1'b1);

    // Asynchronous reset between edges with flits in flight.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h41);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h42);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
    idle(6, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0), 8'($urandom));
    end
    idle(10, 1'b1);
    #5;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised elastic pipeline register: a chain of DEPTH flit-wide register slots with a valid/ready handshake on both sides, bubble collapsing, per-slot load enables, synchronous flush and an occupancy count. It sits on router datapaths wherever a plain enabled register stage must also absorb downstream back-pressure without losing flits. Examples are input-port buffering, crossbar output retiming and ejection-port staging.

## Interface
- WIDTH, 128, data/flit width in bits (>=1)
- DEPTH, 2, number of register slots (1..8; 0 illegal)
- CW, $clog2(DEPTH+1), width of occupancy count (derived, do not override)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; clears all state immediately on assertion
- in_valid  input  1  upstream offers in_data this cycle
- in_ready  output  1  block accepts in_data this cycle (transfer = in_valid & in_ready)
- in_data  input  WIDTH  upstream data
- out_valid  output  1  slot DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts out_data (transfer = out_valid & out_ready)
- out_data  output  WIDTH  contents of slot DEPTH-1
- flush  input  1  synchronous clear of all slots
- count  output  CW  number of valid slots, 0..DEPTH

## Operation
- State: per slot i (0 = input side, DEPTH-1 = output side) a valid bit v[i] and data register d[i].
- Readiness chain, combinational: rdy[DEPTH] = out_ready; rdy[i] = ~v[i] | rdy[i+1] for i = DEPTH-1 down to 0.
- Slot i loads when rdy[i] = 1.
  - Slot 0 takes v[0] <= in_valid & in_ready.
  - Slot i>0 takes v[i] <= v[i-1].
- d[i] is written only when its slot loads a valid value. Otherwise it holds; no toggling on bubbles.
- in_ready = rdy[0] & ~flush.
- out_valid = v[DEPTH-1].
- out_data = d[DEPTH-1].
- Bubbles collapse: an empty slot is filled from upstream even while downstream is stalled.
- Full (count == DEPTH):
  - out_ready = 0 gives in_ready = 0.
  - out_ready = 1 gives in_ready = 1, with simultaneous accept and emit and count unchanged.
- Empty: out_valid = 0. in_ready = 1 unless flush is asserted.
- count is a register equal to popcount(v) after every edge.
  - It is updated by +1 on accept only, -1 on emit only, and unchanged on both or neither.
  - It never exceeds DEPTH and never underflows.
- Flush, for one cycle:
  - in_ready = 0 and no input is accepted.
  - An output transfer in the same cycle (out_valid & out_ready) still completes.
  - At the edge, all v[i] <= 0 and count <= 0. d[i] is not cleared.
- Data ordering is strictly FIFO. No flit is duplicated or dropped except by flush.

## Timing
- Reset (reset = 0, asynchronous): v = 0, d = 0, count = 0, out_valid = 0, out_data = 0. in_ready = 1 whenever flush = 0.
- Reset release: the first accept can occur on the first rising edge with reset = 1.
- Reset asserted mid-operation: all in-flight flits are lost immediately, with no edge required.
- Latency: a flit accepted at edge N into an empty pipe is presented at out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance to output.
  - DEPTH = 1: out_valid the cycle after accept.
- Throughput: 1 flit/cycle sustained while out_ready = 1.
- Combinational paths:
  - out_ready to in_ready, through at most DEPTH AND/OR levels.
  - flush to in_ready.
  - No path from in_valid or in_data to any output.

## Test plan
- Reset and first flit, DEPTH=2, WIDTH=8: hold reset low 3 cycles, release, out_ready=1, send 0xA5 -> out_valid=1, out_data=0xA5 exactly 2 cycles after accept; count 0->1->1->0; all outputs 0 during reset.
- Streaming, DEPTH=3: 20 back-to-back flits 0x00..0x13 with out_ready=1 -> 1 flit/cycle in order, count steady at 3, in_ready never drops.
- Back-pressure fill, DEPTH=4: out_ready=0, offer 6 flits -> 4 accepted, count=4, in_ready=0. Then raise out_ready -> in_ready=1 in the same cycle, flits 0..5 emerge in order.
- Bubble collapse, DEPTH=3: accept one flit, idle one cycle, accept a second, out_ready=0 -> both flits end in slots 2 and 1, count=2.
- Flush, DEPTH=4, count=3, out_valid=1: assert flush with out_ready=1 and in_valid=1 -> output transfer completes, input is not accepted, next cycle count=0 and out_valid=0.
- Asynchronous reset mid-stream: drop reset between edges while count=2 -> out_valid and count go to 0 before the next edge, and no stale flit appears after release.
